// File: rtl/decode_regfile_sb_pkg.sv
`default_nettype none
// ============================================================================
// Package    : decode_pkg
// Purpose    : Shared defaults, types and helpers for the ID-stage register
//              file and load-use scoreboard.
// Contents   : DEF_DATA_W / DEF_NREGS defaults, reg_addr_t, word_t,
//              sb_width() counter-width helper.
// Revision   : 1.0 - initial release
// ============================================================================
package decode_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_NREGS  = 32;
  localparam int DEF_ADDR_W = $clog2(DEF_NREGS);

  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
  typedef logic [DEF_DATA_W-1:0] word_t;

  // Width of a countdown counter that must hold the value LOAD_LAT.
  function automatic int sb_width(input int lat);
    return (lat < 1) ? 1 : $clog2(lat + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/decode_regfile_sb_scoreboard.sv
`default_nettype none
// ============================================================================
// Module     : decode_scoreboard
// Purpose    : Per-register load-use countdown scoreboard. Raises stall when
//              the instruction in ID consumes a register whose load result
//              is not yet available, records issuing loads, and counts
//              stalled cycles.
// Ports      : clk, rst         clock / async active-high reset
//              rd_addr, rd_use  source addresses and their use flags
//              iss_valid, iss_load, iss_dst, flush  instruction in ID
//              stall            load-use hazard
//              busy_vec         per-register pending-load flags
//              stall_cnt        saturating count of stalled cycles
// Revision   : 1.0 - initial release
// ============================================================================
module decode_scoreboard
  import decode_pkg::*;
#(
  parameter int NREGS    = DEF_NREGS,
  parameter int ADDR_W   = $clog2(NREGS),
  parameter int NRD      = 2,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  input  logic [NRD-1:0]        rd_use,
  input  logic                  iss_valid,
  input  logic                  iss_load,
  input  logic [ADDR_W-1:0]     iss_dst,
  input  logic                  flush,
  output logic                  stall,
  output logic [NREGS-1:0]      busy_vec,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam int              SB_W    = sb_width(LOAD_LAT);
  localparam logic [SB_W-1:0] LAT_VAL = SB_W'(LOAD_LAT);

  logic hazard;
  logic iss_fire;
  logic load_set;

  // Hazard is evaluated on the busy state before this cycle's own update,
  // so a load reading its own destination sees the older pending load.
  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < NRD; k++) begin
      if (rd_use[k] && (rd_addr[k*ADDR_W +: ADDR_W] != '0) &&
          busy_vec[rd_addr[k*ADDR_W +: ADDR_W]]) begin
        hazard = 1'b1;
      end
    end
  end

  // A flushed instruction never stalls: it is being discarded anyway.
  assign stall    = iss_valid && !flush && hazard;
  assign iss_fire = iss_valid && !flush && !stall;
  assign load_set = iss_fire && iss_load && (iss_dst != '0);

  generate
    for (genvar r = 0; r < NREGS; r++) begin : g_sb
      if (r == 0) begin : g_zero
        assign busy_vec[r] = 1'b0;
      end else begin : g_cnt
        logic [SB_W-1:0] cnt;

        // A new load on this register restarts the countdown, taking
        // priority over the ordinary decrement.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            cnt <= '0;
          end else if (load_set && (iss_dst == ADDR_W'(r))) begin
            cnt <= LAT_VAL;
          end else if (cnt != '0) begin
            cnt <= cnt - SB_W'(1);
          end
        end

        assign busy_vec[r] = (cnt != '0);
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/decode_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module     : decode_regfile_sb
// Purpose    : ID-stage register file with NRD combinational read ports,
//              write-to-read bypass and a hardwired-zero register 0, plus a
//              load-use scoreboard producing the pipeline stall request.
// Ports      : clk, rst         clock / async active-high reset
//              rd_addr, rd_use  read addresses / operand-consumed flags
//              rd_data          read data, port k at [k*DATA_W +: DATA_W]
//              wr_en, wr_addr, wr_data   writeback port
//              iss_valid, iss_load, iss_dst, flush  instruction in ID
//              stall, busy_vec, stall_cnt  hazard outputs
// Revision   : 1.0 - initial release
// ============================================================================
module decode_regfile_sb
  import decode_pkg::*;
#(
  parameter  int DATA_W   = DEF_DATA_W,
  parameter  int NREGS    = DEF_NREGS,
  parameter  int NRD      = 2,
  parameter  int LOAD_LAT = 1,
  parameter  int CNT_W    = 32,
  localparam int ADDR_W   = $clog2(NREGS)
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  input  logic [NRD-1:0]        rd_use,
  output logic [NRD*DATA_W-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  iss_valid,
  input  logic                  iss_load,
  input  logic [ADDR_W-1:0]     iss_dst,
  input  logic                  flush,
  output logic                  stall,
  output logic [NREGS-1:0]      busy_vec,
  output logic [CNT_W-1:0]      stall_cnt
);

  logic [DATA_W-1:0] regs [NREGS];

  // Register 0 is never written, so its storage stays at the reset value;
  // the read mux also forces it to zero independently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
      end
    end else if (wr_en && (wr_addr != '0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  generate
    for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] word;

      assign addr = rd_addr[k*ADDR_W +: ADDR_W];

      // Same-cycle writeback is forwarded so ID never sees a stale value.
      always_comb begin
        word = regs[addr];
        if (addr == '0) begin
          word = '0;
        end else if (wr_en && (wr_addr == addr)) begin
          word = wr_data;
        end
      end

      assign rd_data[k*DATA_W +: DATA_W] = word;
    end
  endgenerate

  decode_scoreboard #(
    .NREGS    (NREGS),
    .ADDR_W   (ADDR_W),
    .NRD      (NRD),
    .LOAD_LAT (LOAD_LAT),
    .CNT_W    (CNT_W)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .rd_addr   (rd_addr),
    .rd_use    (rd_use),
    .iss_valid (iss_valid),
    .iss_load  (iss_load),
    .iss_dst   (iss_dst),
    .flush     (flush),
    .stall     (stall),
    .busy_vec  (busy_vec),
    .stall_cnt (stall_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_decode_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module     : tb_decode_regfile_sb
// Purpose    : Self-checking bench for decode_regfile_sb. Two instances
//              (load latency 1 and 3) share one stimulus stream; a reference
//              model tracks register contents and, per register, the cycle
//              at which a pending load result becomes available.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_decode_regfile_sb;

  localparam int AW  = 5;
  localparam int NRD = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [9:0]    rd_addr;
  logic [1:0]    rd_use;
  logic          wr_en;
  logic [4:0]    wr_addr;
  logic [31:0]   wr_data;
  logic          iss_valid, iss_load, flush;
  logic [4:0]    iss_dst;

  logic [63:0]   rd_data1, rd_data3;
  logic          stall1, stall3;
  logic [31:0]   busy1, busy3;
  logic [31:0]   cnt1, cnt3;

  always #5 clk = ~clk;

  decode_regfile_sb #(.DATA_W(32), .NREGS(32), .NRD(NRD), .LOAD_LAT(1), .CNT_W(32)) u_dut1 (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_use(rd_use), .rd_data(rd_data1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_valid(iss_valid), .iss_load(iss_load), .iss_dst(iss_dst), .flush(flush),
    .stall(stall1), .busy_vec(busy1), .stall_cnt(cnt1));

  decode_regfile_sb #(.DATA_W(32), .NREGS(32), .NRD(NRD), .LOAD_LAT(3), .CNT_W(32)) u_dut3 (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_use(rd_use), .rd_data(rd_data3),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_valid(iss_valid), .iss_load(iss_load), .iss_dst(iss_dst), .flush(flush),
    .stall(stall3), .busy_vec(busy3), .stall_cnt(cnt3));

  int n_chk  = 0;
  int n_pass = 0;

  // ---------------- reference model ----------------
  logic [31:0]  m_regs [32];
  longint       ready1 [32];   // first cycle at which reg is free again
  longint       ready3 [32];
  longint       cyc;
  int unsigned  m_cnt1, m_cnt3;

  function automatic logic [31:0] m_rd(input int k);
    logic [4:0] a;
    a = rd_addr[k*AW +: AW];
    if (a == 5'd0) return 32'd0;
    if (wr_en && wr_addr == a) return wr_data;
    return m_regs[a];
  endfunction

  function automatic logic [31:0] m_busy(input int lat);
    logic [31:0] b;
    b = '0;
    for (int r = 1; r < 32; r++) b[r] = ((lat == 1) ? ready1[r] : ready3[r]) > cyc;
    return b;
  endfunction

  function automatic logic m_stall(input int lat);
    logic [31:0] b;
    logic        h;
    logic [4:0]  a;
    b = m_busy(lat);
    h = 1'b0;
    for (int k = 0; k < NRD; k++) begin
      a = rd_addr[k*AW +: AW];
      if (rd_use[k] && a != 5'd0 && b[a]) h = 1'b1;
    end
    return iss_valid && !flush && h;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_regs[r] = '0; ready1[r] = 0; ready3[r] = 0;
    end
    cyc = 0; m_cnt1 = 0; m_cnt3 = 0;
  endtask

  // Advance one clock; the model consumes the inputs held across the edge.
  task automatic tick();
    logic s1, s3;
    s1 = m_stall(1);
    s3 = m_stall(3);
    @(posedge clk);
    if (wr_en && wr_addr != 5'd0) m_regs[wr_addr] = wr_data;
    if (iss_valid && !flush && iss_load && iss_dst != 5'd0) begin
      if (!s1) ready1[iss_dst] = cyc + 1 + 1;
      if (!s3) ready3[iss_dst] = cyc + 1 + 3;
    end
    if (s1 && m_cnt1 != 32'hFFFF_FFFF) m_cnt1++;
    if (s3 && m_cnt3 != 32'hFFFF_FFFF) m_cnt3++;
    cyc++;
    #1;
  endtask

  task automatic drive_idle();
    rd_addr = '0; rd_use = '0; wr_en = 0; wr_addr = '0; wr_data = '0;
    iss_valid = 0; iss_load = 0; iss_dst = '0; flush = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    rd_addr = {5'd5, 5'd0};
    #1;
    n_chk++; if (rd_data1 !== 64'd0) $display("FAIL reset_rd_data1 got %h want 0", rd_data1); else n_pass++;
    n_chk++; if (rd_data3 !== 64'd0) $display("FAIL reset_rd_data3 got %h want 0", rd_data3); else n_pass++;
    n_chk++; if (busy1 !== 32'd0 || busy3 !== 32'd0) $display("FAIL reset_busy got %h/%h want 0", busy1, busy3); else n_pass++;
    n_chk++; if (stall1 !== 1'b0 || stall3 !== 1'b0) $display("FAIL reset_stall got %b/%b want 0", stall1, stall3); else n_pass++;
    n_chk++; if (cnt1 !== 32'd0 || cnt3 !== 32'd0) $display("FAIL reset_stall_cnt got %0d/%0d want 0", cnt1, cnt3); else n_pass++;
  endtask

  task automatic test_bypass();
    wr_en = 1; wr_addr = 5'd3; wr_data = 32'hDEADBEEF; rd_addr = {5'd0, 5'd3};
    #1;
    n_chk++; if (rd_data1[31:0] !== 32'hDEADBEEF) $display("FAIL bypass_r3 got %h want deadbeef", rd_data1[31:0]); else n_pass++;
    tick();
    wr_en = 0; rd_addr = {5'd3, 5'd0};
    #1;
    n_chk++; if (rd_data3[63:32] !== 32'hDEADBEEF) $display("FAIL stored_r3 got %h want deadbeef", rd_data3[63:32]); else n_pass++;
    wr_en = 1; wr_addr = 5'd0; wr_data = 32'h1; rd_addr = {5'd0, 5'd0};
    #1;
    n_chk++; if (rd_data1 !== 64'd0) $display("FAIL r0_bypass got %h want 0", rd_data1); else n_pass++;
    tick();
    wr_en = 0;
    #1;
    n_chk++; if (rd_data1 !== 64'd0) $display("FAIL r0_write got %h want 0", rd_data1); else n_pass++;
  endtask

  task automatic test_load_lat1();
    iss_valid = 1; iss_load = 1; iss_dst = 5'd4; rd_use = 2'b00;
    #1;
    n_chk++; if (stall1 !== 1'b0) $display("FAIL lat1_load_issue stall got %b want 0", stall1); else n_pass++;
    tick();
    iss_load = 0; iss_dst = 5'd8; rd_use = 2'b10; rd_addr = {5'd4, 5'd0};
    #1;
    n_chk++; if (stall1 !== 1'b1) $display("FAIL lat1_dep_stall got %b want 1", stall1); else n_pass++;
    n_chk++; if (busy1[4] !== 1'b1) $display("FAIL lat1_busy4 got %b want 1", busy1[4]); else n_pass++;
    tick();
    #1;
    n_chk++; if (stall1 !== 1'b0) $display("FAIL lat1_dep_release got %b want 0", stall1); else n_pass++;
    n_chk++; if (cnt1 !== 32'd1) $display("FAIL lat1_stall_cnt got %0d want 1", cnt1); else n_pass++;
    drive_idle();
    repeat (4) tick();
  endtask

  task automatic test_load_lat3();
    iss_valid = 1; iss_load = 1; iss_dst = 5'd7;
    tick();
    iss_load = 0; iss_dst = 5'd1; rd_use = 2'b01; rd_addr = {5'd0, 5'd7};
    for (int i = 0; i < 4; i++) begin
      #1;
      n_chk++; if (stall3 !== (i < 3)) $display("FAIL lat3_stall c%0d got %b want %b", i, stall3, i < 3); else n_pass++;
      n_chk++; if (busy3[7] !== (i < 3)) $display("FAIL lat3_busy7 c%0d got %b want %b", i, busy3[7], i < 3); else n_pass++;
      tick();
    end
    drive_idle();
    tick();
    iss_valid = 1; iss_load = 1; iss_dst = 5'd7;
    tick();
    iss_load = 0; iss_dst = 5'd1; rd_use = 2'b01; rd_addr = {5'd0, 5'd7};
    for (int i = 0; i < 4; i++) begin
      flush = (i == 1);
      #1;
      n_chk++; if (stall3 !== (i == 0 || i == 2)) $display("FAIL lat3_flush_stall c%0d got %b want %b", i, stall3, i == 0 || i == 2); else n_pass++;
      n_chk++; if (busy3[7] !== (i < 3)) $display("FAIL lat3_flush_busy7 c%0d got %b want %b", i, busy3[7], i < 3); else n_pass++;
      tick();
    end
    drive_idle();
    repeat (4) tick();
  endtask

  task automatic test_no_record();
    iss_valid = 1; iss_load = 1; iss_dst = 5'd4;
    tick();
    iss_dst = 5'd9; rd_use = 2'b01; rd_addr = {5'd0, 5'd4};
    #1;
    n_chk++; if (stall3 !== 1'b1 || stall1 !== 1'b1) $display("FAIL stalled_load_stall got %b/%b want 1/1", stall1, stall3); else n_pass++;
    tick();
    n_chk++; if (busy1[9] !== 1'b0 || busy3[9] !== 1'b0) $display("FAIL stalled_load_busy9 got %b/%b want 0/0", busy1[9], busy3[9]); else n_pass++;
    iss_load = 0; rd_use = 2'b00;
    #1;
    n_chk++; if (busy3[4] !== 1'b1) $display("FAIL unused_busy4 got %b want 1", busy3[4]); else n_pass++;
    n_chk++; if (stall3 !== 1'b0) $display("FAIL unused_operand_stall got %b want 0", stall3); else n_pass++;
    tick();
    iss_load = 1; iss_dst = 5'd9; flush = 1;
    tick();
    drive_idle();
    #1;
    n_chk++; if (busy1[9] !== 1'b0 || busy3[9] !== 1'b0) $display("FAIL flushed_load_busy9 got %b/%b want 0/0", busy1[9], busy3[9]); else n_pass++;
    iss_valid = 1; iss_load = 1; iss_dst = 5'd0;
    tick();
    drive_idle();
    #1;
    n_chk++; if (busy1 !== m_busy(1)) $display("FAIL load_r0_busy1 got %h want %h", busy1, m_busy(1)); else n_pass++;
    n_chk++; if (busy3 !== m_busy(3)) $display("FAIL load_r0_busy3 got %h want %h", busy3, m_busy(3)); else n_pass++;
    repeat (4) tick();
  endtask

  task automatic test_async_reset();
    iss_valid = 1; iss_load = 1; iss_dst = 5'd6;
    tick();
    iss_load = 0; iss_dst = 5'd2; rd_use = 2'b01; rd_addr = {5'd0, 5'd6};
    tick();
    #1;
    n_chk++; if (stall3 !== 1'b1) $display("FAIL pre_reset_stall got %b want 1", stall3); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_chk++; if (busy3 !== 32'd0 || busy1 !== 32'd0) $display("FAIL async_rst_busy got %h/%h want 0", busy1, busy3); else n_pass++;
    n_chk++; if (stall3 !== 1'b0) $display("FAIL async_rst_stall got %b want 0", stall3); else n_pass++;
    n_chk++; if (cnt3 !== 32'd0 || cnt1 !== 32'd0) $display("FAIL async_rst_stall_cnt got %0d/%0d want 0", cnt1, cnt3); else n_pass++;
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    rd_addr = {5'd3, 5'd6};
    #1;
    n_chk++; if (stall3 !== 1'b0 || busy3 !== 32'd0) $display("FAIL post_rst_state got %b/%h want 0/0", stall3, busy3); else n_pass++;
    n_chk++; if (rd_data3 !== 64'd0) $display("FAIL post_rst_rd_data got %h want 0", rd_data3); else n_pass++;
    drive_idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rd_addr   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      rd_use    = 2'($urandom);
      wr_en     = 1'($urandom);
      wr_addr   = 5'($urandom_range(0, 7));
      wr_data   = $urandom;
      iss_valid = ($urandom_range(0, 3) != 0);
      iss_load  = 1'($urandom);
      iss_dst   = 5'($urandom_range(0, 7));
      flush     = ($urandom_range(0, 7) == 0);
      #1;
      n_chk++; if (rd_data1 !== {m_rd(1), m_rd(0)}) $display("FAIL rnd_rd_data1 i%0d got %h want %h", i, rd_data1, {m_rd(1), m_rd(0)}); else n_pass++;
      n_chk++; if (rd_data3 !== {m_rd(1), m_rd(0)}) $display("FAIL rnd_rd_data3 i%0d got %h want %h", i, rd_data3, {m_rd(1), m_rd(0)}); else n_pass++;
      n_chk++; if (stall1 !== m_stall(1)) $display("FAIL rnd_stall1 i%0d got %b want %b", i, stall1, m_stall(1)); else n_pass++;
      n_chk++; if (stall3 !== m_stall(3)) $display("FAIL rnd_stall3 i%0d got %b want %b", i, stall3, m_stall(3)); else n_pass++;
      n_chk++; if (busy1 !== m_busy(1)) $display("FAIL rnd_busy1 i%0d got %h want %h", i, busy1, m_busy(1)); else n_pass++;
      n_chk++; if (busy3 !== m_busy(3)) $display("FAIL rnd_busy3 i%0d got %h want %h", i, busy3, m_busy(3)); else n_pass++;
      n_chk++; if (cnt1 !== m_cnt1) $display("FAIL rnd_cnt1 i%0d got %0d want %0d", i, cnt1, m_cnt1); else n_pass++;
      n_chk++; if (cnt3 !== m_cnt3) $display("FAIL rnd_cnt3 i%0d got %0d want %0d", i, cnt3, m_cnt3); else n_pass++;
      tick();
    end
    drive_idle();
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    model_reset();
    test_reset();
    test_bypass();
    test_load_lat1();
    test_load_lat3();
    test_no_record();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
